// File: rtl/ext_link_pkg.sv
// Shared definitions for the board-to-board external link (receiver and
// transmitter): receiver state codes and the serial frame levels.
package ext_link_pkg;

  // Receiver FSM states; the codes are visible on rx_state for debug LEDs.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    ACK       = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // Frame format: one start bit, DATA_BITS data bits LSB-first, one stop bit.
  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/ext_link_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset value
// is a parameter so an idle-high line does not look like an edge out of reset.
module ext_link_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage shift toward clk; the first stage may go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // giving a true two-stage pipeline instead of a single wire-through.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ext_link_rx.sv
// Receiver for the external link: oversamples the line on the baud tick,
// de-frames 8-bit words, strobes each good word and answers with an ack pulse.
module ext_link_rx
  import ext_link_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int ACK_BITS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       receiver_en,
  input  logic       ext_data_in,
  output logic       ack_out,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic [2:0] rx_state
);

  localparam int TW        = $clog2(OVERSAMPLE);
  localparam int ACK_TICKS = ACK_BITS * OVERSAMPLE;
  localparam int AW        = $clog2(ACK_TICKS);

  localparam logic [TW-1:0] T_HALF   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [AW-1:0] A_LAST   = AW'(ACK_TICKS - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_d;
  logic          valid_d, ferr_d, ack_d;
  logic          rxd;

  ext_link_sync #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_data_in),
    .q     (rxd)
  );

  assign rx_state = state_q;

  // Next-state, counter and output decode.
  always_comb begin
    // NOTE: every variable gets its default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    acnt_d  = acnt_q;
    shift_d = shift_q;
    data_d  = data_out;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (!receiver_en && state_q != ACK) begin
      // Disabling drops any partial word; an ack in progress still completes.
      state_d = IDLE;
      tcnt_d  = '0;
      bcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rxd == START_LEVEL) begin
            state_d = START;
            tcnt_d  = '0;
          end
        end

        START: begin
          if (tick) begin
            if (tcnt_q == T_HALF) begin
              tcnt_d = '0;
              if (rxd == START_LEVEL) begin
                state_d = DATA;
                bcnt_d  = '0;
              end else begin
                state_d = IDLE;  // too short to be a start bit
              end
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (tcnt_q == T_LAST) begin
              tcnt_d  = '0;
              shift_d = {rxd, shift_q[7:1]};
              if (bcnt_q == BIT_LAST) begin
                state_d = STOP;
                bcnt_d  = '0;
              end else begin
                bcnt_d = bcnt_q + 3'd1;
              end
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (tcnt_q == T_LAST) begin
              tcnt_d = '0;
              if (rxd == STOP_LEVEL) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                acnt_d  = '0;
                state_d = ACK;
              end else begin
                ferr_d  = 1'b1;
                state_d = WAIT_HIGH;
              end
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end

        ACK: begin
          if (tick) begin
            if (acnt_q == A_LAST) begin
              acnt_d  = '0;
              state_d = IDLE;
            end else begin
              acnt_d = acnt_q + AW'(1);
            end
          end
        end

        WAIT_HIGH: begin
          // A held-low line (break) must not restart reception.
          if (tick && rxd == IDLE_LEVEL) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    ack_d = (state_d == ACK);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      acnt_q     <= '0;
      shift_q    <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      ack_out    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      acnt_q     <= acnt_d;
      shift_q    <= shift_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      frame_err  <= ferr_d;
      ack_out    <= ack_d;
    end
  end

endmodule

// File: doc/ext_link_rx.md
# ext_link_rx

Serial receiver for the board-to-board external link; the receiving end of the link transmitter that drives `ext_data_out` and waits on `ack_in`. It oversamples the incoming line on the shared baud `tick`, de-frames 8-bit words (start, 8 data bits LSB-first, stop), presents each good word with a one-cycle valid strobe, and answers with an acknowledge pulse on `ack_out`. It sits between the GPIO pin pair (`ext_data_in`/`ack_out`) and the bus-side slave that consumes received data.

## Interface
- `OVERSAMPLE`, 16: `tick` pulses per bit period; even, ≥4.
- `ACK_BITS`, 2: length of the `ack_out` pulse, in bit periods.
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: asynchronous, active-high; all state cleared immediately.
- `tick` in 1: one-`clk` strobe at `OVERSAMPLE`× the baud rate.
- `receiver_en` in 1: level; 0 holds the block in IDLE.
- `ext_data_in` in 1: asynchronous serial line, idle high.
- `ack_out` out 1: acknowledge to the far transmitter, active-high.
- `data_out` out 8: last good word; holds until the next good frame.
- `data_valid` out 1: one-`clk` pulse when `data_out` updates.
- `frame_err` out 1: one-`clk` pulse on a bad stop bit.
- `rx_state` out 3: current FSM state code, for LED/7-seg debug.

## Operation
- `ext_data_in` passes through a 2-flop synchronizer; all decisions use the synchronized value `rxd`.
- Tick counter `tcnt` (width clog2(OVERSAMPLE)) and bit counter `bcnt` (3 bits) advance only on `tick`.
- States/codes: IDLE=0, START=1, DATA=2, STOP=3, ACK=4, WAIT_HIGH=5.
- IDLE: when `receiver_en`=1 and `rxd`=0, go to START with `tcnt`=0.
- START: at `tcnt`=OVERSAMPLE/2−1, if `rxd`=0, go to DATA with `tcnt`=0 and `bcnt`=0. Otherwise it was a glitch: go to IDLE with no strobe.
- DATA: at `tcnt`=OVERSAMPLE−1, shift `rxd` into the MSB of the shift register (LSB-first framing) and reset `tcnt`. After `bcnt`=7 is sampled, go to STOP.
- STOP: at `tcnt`=OVERSAMPLE−1, sample `rxd`.
  - 1: load `data_out`, pulse `data_valid`, go to ACK.
  - 0: pulse `frame_err`, leave `data_out` unchanged, go to WAIT_HIGH.
- ACK: hold `ack_out`=1 for exactly ACK_BITS×OVERSAMPLE ticks, then go to IDLE. New start bits are ignored while in ACK; the transmitter must not send before the ack ends.
- WAIT_HIGH: go to IDLE on the first `tick` with `rxd`=1. This blocks a break condition from re-triggering.
- `receiver_en`→0 in any state other than ACK: next `clk` goes to IDLE. The partial word is discarded and no strobe is issued.
- `receiver_en`→0 in ACK: the ack still completes.
- Reset values: state IDLE, `ack_out`=0, `data_out`=8'h00, `data_valid`=0, `frame_err`=0, counters 0, synchronizer flops 1.

## Timing
- Sampling point is mid-bit: OVERSAMPLE/2 ticks after the detected falling edge, then every OVERSAMPLE ticks.
- Detection latency is 2 `clk` (synchronizer) plus up to 1 tick.
- `data_valid`, `frame_err` and the `ack_out` rising edge occur on the `clk` edge after the stop-bit sample tick, all on the same edge.
- `ack_out` falls on the `clk` after the ACK_BITS×OVERSAMPLE-th tick in ACK.
- All outputs are registered. `rx_state` reflects the current state register.
- Ticks are never skipped or merged; a `tick` held high for more than one `clk` counts once per cycle high. Upstream guarantees single-cycle ticks.

## Structure
- Package `ext_link_pkg` holds:
  - the state enum and its 3-bit codes;
  - the frame constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.

  The transmitter shares this package.
- Sub-module `ext_link_sync` is the 2-flop synchronizer with a reset value parameter. It is reused for `ack_in` on the transmitter side.
- The FSM, counters and shift register live in `ext_link_rx`.

## Test plan
- Send 0xA5 framed at OVERSAMPLE=16: `data_out`=0xA5 with one `data_valid` pulse; `ack_out` high for exactly 32 ticks; `rx_state` sequence 0,1,2,3,4,0.
- Send back-to-back 0x00 then 0xFF, the second start bit right after the ack ends: two `data_valid` pulses; `data_out` is 0x00, then 0xFF.
- 4-tick low glitch on an idle line: returns to IDLE; no `data_valid`, `frame_err` or `ack_out`; `data_out` unchanged.
- Frame 0x3C with stop bit forced low for 3 bit periods: one `frame_err` pulse, no ack, `data_out` keeps its old value, state 5 until the line goes high, then 0.
- `receiver_en` dropped after 4 data bits: IDLE next `clk`, no strobes. Re-enable and send 0x81: received correctly.
- `reset` asserted mid-DATA and mid-ACK: `ack_out`, `data_valid` and `frame_err` go 0 immediately, `data_out`=0x00, state 0; the next frame 0x5A is received correctly.
